// File: rtl/mux_pipe_nto1_pkg.sv
// Shared definitions for the pipelined N:1 multiplexer: select-width helper
// and the fill value used when an out-of-range select is accepted.
package mux_defs;

  // N=2 still needs one select bit; $clog2(2) would also give 1, but N=1 would not.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam logic SEL_FILL_BIT = 1'b0;

endpackage

// File: rtl/mux_pipe_nto1_comb.sv
// Pure combinational N:1 selector; flags selects that do not name an input.
module mux_comb_nto1
  import mux_defs::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = sel_width(N)
) (
  input  logic [N*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   data_out,
  output logic               sel_oob
);

  assign sel_oob = (int'(sel) >= N);

  always_comb begin
    // NOTE: default assignment first so no path through the loop leaves data_out unassigned (no latch).
    data_out = {WIDTH{SEL_FILL_BIT}};
    for (int k = 0; k < N; k++) begin
      if (sel == SEL_W'(k)) data_out = data_in[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mux_pipe_nto1.sv
// Registered N:1 mux with valid/ready on both sides and a sticky select-error flag.
// Define MUX_SKID_EN to add a skid entry and make in_ready a registered signal.
module mux_pipe_nto1
  import mux_defs::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = sel_width(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sel_err
);

  logic [WIDTH-1:0] sel_data;
  logic             sel_oob;
  logic             accept;

  mux_comb_nto1 #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) u_sel (
    .data_in  (in_data),
    .sel      (in_sel),
    .data_out (sel_data),
    .sel_oob  (sel_oob)
  );

  assign accept = in_valid && in_ready;

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)                    sel_err <= 1'b0;
    else if (accept && sel_oob) sel_err <= 1'b1;
  end

`ifdef MUX_SKID_EN
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;

  // Only the rst gate is combinational; nothing from out_ready reaches in_ready.
  assign in_ready = !rst && !skid_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      // NOTE: data registers are reset too, since out_data is required to read zero after reset.
      skid_data  <= '0;
    end else if (skid_valid) begin
      // Skid drains first; no accept is possible while it is occupied.
      if (out_ready) begin
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!out_valid || out_ready) begin
        out_data  <= sel_data;
        out_valid <= 1'b1;
      end else begin
        skid_data  <= sel_data;
        skid_valid <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`else
  assign in_ready = !rst && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_data  <= sel_data;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule
